bcd_stopwatch_ctrl: RTL and testbench



---
 rtl/bcd_stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: debounced start/stop + clear buttons driving a
// two-digit BCD stopwatch count (00-99) for the 7-segment display stage.
module bcd_stopwatch_ctrl #(
    parameter int unsigned TICK_CYCLES     = 2_500_000,
    parameter int unsigned DEBOUNCE_CYCLES = 250_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    output logic [3:0] o_Tens,
    output logic [3:0] o_Units,
    output logic       o_Running,
    output logic       o_Wrap
);

    localparam int unsigned TW = $clog2(TICK_CYCLES);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] ST_STOPPED = 1'b0;
    localparam logic [0:0] ST_RUNNING = 1'b1;

    // bit 0: start/stop, bit 1: clear
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_q;
    logic [1:0]    armed;
    logic [1:0]    sync_vld;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];

    logic [0:0]    state;
    logic [TW-1:0] tick_cnt;
    logic          tick_done;
    logic          start_p;
    logic          clear_p;

    assign raw = {i_Switch_2, i_Switch_1};

    // Two-flop synchronizers for the asynchronous button inputs
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debouncers: accept a new level only after DEBOUNCE_CYCLES of disagreement
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            deb <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Edge-detect history and press arming. A button must be seen released
    // (after the synchronizer holds real samples) before its rise counts, so
    // a button held through reset does not fire when the debouncer catches up.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            deb_q    <= '0;
            armed    <= '0;
            sync_vld <= '0;
        end else begin
            deb_q    <= deb;
            sync_vld <= {sync_vld[0], 1'b1};
            armed    <= armed | ({2{sync_vld[1]}} & ~sync2);
        end
    end

    // Press events and terminal-tick decode
    always_comb begin
        press     = deb & ~deb_q & armed;
        start_p   = press[0];
        clear_p   = press[1];
        tick_done = (state == ST_RUNNING) && (tick_cnt == TICK_LAST);
    end

    // Start/stop state machine; clear forces STOPPED and wins over start
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= ST_STOPPED;
        end else if (clear_p) begin
            state <= ST_STOPPED;
        end else if (start_p) begin
            state <= (state == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
        end
    end

    // Time-base counter: runs only in RUNNING, restarts on any state change
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tick_cnt <= '0;
        end else if (clear_p || start_p || (state == ST_STOPPED) || tick_done) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // BCD count and wrap pulse; a terminal tick still counts on a stop press
    always_ff @(posedge i_Clk) begin
        if (i_Rst || clear_p) begin
            o_Tens  <= '0;
            o_Units <= '0;
            o_Wrap  <= 1'b0;
        end else begin
            o_Wrap <= 1'b0;
            if (tick_done) begin
                if (o_Units != 4'd9) begin
                    o_Units <= o_Units + 4'd1;
                end else if (o_Tens != 4'd9) begin
                    o_Units <= '0;
                    o_Tens  <= o_Tens + 4'd1;
                end else begin
                    o_Units <= '0;
                    o_Tens  <= '0;
                    o_Wrap  <= 1'b1;
                end
            end
        end
    end

    assign o_Running = state[0];

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed self-checking bench for bcd_stopwatch_ctrl (TICK=10, DEBOUNCE=4).
module tb_bcd_stopwatch_ctrl;

    logic       clk;
    logic       rst;
    logic       sw1;
    logic       sw2;
    logic [3:0] tens;
    logic [3:0] units;
    logic       running;
    logic       wrap;
    logic [9:0] obs;

    int checks;
    int failures;

    bcd_stopwatch_ctrl #(
        .TICK_CYCLES(10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Switch_1(sw1),
        .i_Switch_2(sw2),
        .o_Tens(tens),
        .o_Units(units),
        .o_Running(running),
        .o_Wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observed outputs packed as {tens, units, running, wrap}
    assign obs = {tens, units, running, wrap};

    // advance n edges, land 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sw1 = 1'b0;
        sw2 = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(4);
    endtask

    // raise start; returns right after the edge where the press takes effect
    task automatic do_start();
        sw1 = 1'b1;
        step(7);
        sw1 = 1'b0;
    endtask

    task automatic test_reset();
        sw1 = 1'b1;
        sw2 = 1'b1;
        rst = 1'b1;
        step(2);
        checks++;
        if (obs !== 10'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, 10'h000);
        end
        rst = 1'b0;
        step(30);
        checks++;
        if (obs !== 10'h000) begin
            failures++;
            $display("FAIL reset_release_held got=%h exp=%h", obs, 10'h000);
        end
        sw1 = 1'b0;
        sw2 = 1'b0;
        step(10);
    endtask

    task automatic test_start_run();
        do_reset();
        sw1 = 1'b1;
        step(6);
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL start_edge6 got=%b exp=0", running);
        end
        step(1);
        checks++;
        if (obs !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL start_edge7 got=%h exp=%h", obs, {4'd0, 4'd0, 1'b1, 1'b0});
        end
        step(9);
        checks++;
        if (units !== 4'd0) begin
            failures++;
            $display("FAIL first_tick_early got=%0d exp=0", units);
        end
        step(1);
        checks++;
        if (units !== 4'd1) begin
            failures++;
            $display("FAIL first_tick got=%0d exp=1", units);
        end
        step(3);
        sw1 = 1'b0;
        step(6);
        checks++;
        if (units !== 4'd1) begin
            failures++;
            $display("FAIL second_tick_early got=%0d exp=1", units);
        end
        step(1);
        checks++;
        if (units !== 4'd2) begin
            failures++;
            $display("FAIL second_tick got=%0d exp=2", units);
        end
        step(10);
        checks++;
        if (obs !== {4'd0, 4'd3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL third_tick got=%h exp=%h", obs, {4'd0, 4'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        do_start();
        step(475);
        checks++;
        if (obs !== {4'd4, 4'd7, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL count_47 got=%h exp=%h", obs, {4'd4, 4'd7, 1'b1, 1'b0});
        end
        step(515);
        checks++;
        if (obs !== {4'd9, 4'd9, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL count_99 got=%h exp=%h", obs, {4'd9, 4'd9, 1'b1, 1'b0});
        end
        step(9);
        checks++;
        if (obs !== {4'd9, 4'd9, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL pre_wrap got=%h exp=%h", obs, {4'd9, 4'd9, 1'b1, 1'b0});
        end
        step(1);
        checks++;
        if (obs !== {4'd0, 4'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL wrap_pulse got=%h exp=%h", obs, {4'd0, 4'd0, 1'b1, 1'b1});
        end
        step(1);
        checks++;
        if (obs !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL wrap_one_cycle got=%h exp=%h", obs, {4'd0, 4'd0, 1'b1, 1'b0});
        end
        step(9);
        checks++;
        if (obs !== {4'd0, 4'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL after_wrap got=%h exp=%h", obs, {4'd0, 4'd1, 1'b1, 1'b0});
        end
    endtask

    task automatic test_glitch();
        do_reset();
        do_start();
        step(10);
        for (int i = 0; i < 3; i++) begin
            sw1 = 1'b1;
            step(3);
            sw1 = 1'b0;
            step(5);
            sw2 = 1'b1;
            step(1);
            sw2 = 1'b0;
            step(1);
        end
        checks++;
        if (obs !== {4'd0, 4'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL glitch_running got=%h exp=%h", obs, {4'd0, 4'd4, 1'b1, 1'b0});
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sw1 = 1'b1;
            sw2 = 1'b1;
            step(1);
            sw2 = 1'b0;
            step(2);
            sw1 = 1'b0;
            step(5);
        end
        checks++;
        if (obs !== 10'h000) begin
            failures++;
            $display("FAIL glitch_stopped got=%h exp=%h", obs, 10'h000);
        end
    endtask

    task automatic test_pause();
        do_reset();
        do_start();
        step(470);
        do_start();
        checks++;
        if (obs !== {4'd4, 4'd7, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL pause_at_47 got=%h exp=%h", obs, {4'd4, 4'd7, 1'b0, 1'b0});
        end
        step(20);
        checks++;
        if (obs !== {4'd4, 4'd7, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL paused_frozen got=%h exp=%h", obs, {4'd4, 4'd7, 1'b0, 1'b0});
        end
        do_start();
        step(9);
        checks++;
        if (obs !== {4'd4, 4'd7, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL resume_early got=%h exp=%h", obs, {4'd4, 4'd7, 1'b1, 1'b0});
        end
        step(1);
        checks++;
        if (obs !== {4'd4, 4'd8, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL resume_tick got=%h exp=%h", obs, {4'd4, 4'd8, 1'b1, 1'b0});
        end
        // stop press lands on the next terminal tick edge
        step(3);
        do_start();
        checks++;
        if (obs !== {4'd4, 4'd9, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stop_on_tick got=%h exp=%h", obs, {4'd4, 4'd9, 1'b0, 1'b0});
        end
        step(15);
        checks++;
        if (obs !== {4'd4, 4'd9, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stop_on_tick_hold got=%h exp=%h", obs, {4'd4, 4'd9, 1'b0, 1'b0});
        end
    endtask

    task automatic test_both_and_reset();
        do_reset();
        do_start();
        step(230);
        checks++;
        if (obs !== {4'd2, 4'd3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL count_23 got=%h exp=%h", obs, {4'd2, 4'd3, 1'b1, 1'b0});
        end
        sw1 = 1'b1;
        sw2 = 1'b1;
        step(7);
        checks++;
        if (obs !== 10'h000) begin
            failures++;
            $display("FAIL clear_wins got=%h exp=%h", obs, 10'h000);
        end
        sw1 = 1'b0;
        sw2 = 1'b0;
        step(12);
        checks++;
        if (obs !== 10'h000) begin
            failures++;
            $display("FAIL clear_hold got=%h exp=%h", obs, 10'h000);
        end
        do_start();
        step(15);
        checks++;
        if (obs !== {4'd0, 4'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL pre_midreset got=%h exp=%h", obs, {4'd0, 4'd1, 1'b1, 1'b0});
        end
        rst = 1'b1;
        step(1);
        checks++;
        if (obs !== 10'h000) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", obs, 10'h000);
        end
        rst = 1'b0;
        step(20);
        checks++;
        if (obs !== 10'h000) begin
            failures++;
            $display("FAIL post_midreset got=%h exp=%h", obs, 10'h000);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        sw1      = 1'b0;
        sw2      = 1'b0;
        #2;
        test_reset();
        test_start_run();
        test_wrap();
        test_glitch();
        test_pause();
        test_both_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
